hazard_control: RTL and testbench
=================================

# hazard_control

Pipeline hazard controller for the 5-stage CPU. Sits beside the forwarding unit and sequences the pipeline registers. It handles three cases: load-use stalls that forwarding cannot cover, IF/ID and ID/EX flushes after a taken branch, and a full-pipeline freeze while the data-memory request/acknowledge handshake is outstanding. It drives PC, pipeline-register write enables and flush/bubble controls.

## Interface
- FLUSH_CYCLES, 1: cycles IF_ID_Flush/ID_EX_Flush stay asserted per taken branch (1..7).
- MEM_TIMEOUT, 255: maximum consecutive freeze cycles waiting for dmem_ack (2..255).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_Rw  in  5  destination register of instruction in EX.
- IF_ID_Ra  in  5  source A of instruction in ID.
- IF_ID_Rb  in  5  source B of instruction in ID.
- IF_ID_UseRb  in  1  ID instruction reads Rb.
- EX_Branch_Taken  in  1  branch in EX resolved taken.
- EX_MEM_MemAccess  in  1  instruction in MEM accesses data memory.
- dmem_ack  in  1  data memory completes access this cycle.
- dmem_req  out  1  data memory request.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- ID_EX_Write, EX_MEM_Write  out  1  pipeline register write enables.
- MEM_WB_Bubble  out  1  insert NOP into MEM/WB.
- ID_EX_Bubble  out  1  load-use bubble into ID/EX.
- IF_ID_Flush, ID_EX_Flush  out  1  branch flush.
- mem_fault  out  1  one-cycle pulse on handshake timeout.
- stall_cycles  out  32  perf counter (see Configuration).
- flush_count  out  16  perf counter (see Configuration).

## Operation
- States: RUN, MEM_WAIT, FLUSH. Registers: state, wait_cnt (8 bit), flush_cnt (3 bit).
- dmem_req = EX_MEM_MemAccess in RUN/FLUSH. In MEM_WAIT, dmem_req = 1 except in the timeout cycle.
- freeze = dmem_req & ~dmem_ack. While freeze is high:
  - PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write are 0.
  - MEM_WB_Bubble is 1.
  - Flushes and the load-use bubble are suppressed.
- RUN + freeze → MEM_WAIT, with wait_cnt = 1.
- MEM_WAIT with ack → RUN. The pipeline advances in the ack cycle.
- MEM_WAIT without ack and wait_cnt < MEM_TIMEOUT → stay, wait_cnt++.
- MEM_WAIT without ack and wait_cnt == MEM_TIMEOUT → timeout cycle:
  - mem_fault=1, dmem_req=0, freeze=0, so the pipeline advances.
  - Next state is RUN.
- Taken branch (EX_Branch_Taken & ~freeze):
  - IF_ID_Flush and ID_EX_Flush assert that cycle.
  - If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1. Flushes stay asserted until flush_cnt reaches 0, then return to RUN.
  - A taken branch while in FLUSH reloads flush_cnt.
- A taken branch during a freeze is held in EX by the freeze and acts on the release cycle.
- Load-use condition:
  - ID_EX_MemRead & ID_EX_Rw != 31, and
  - (ID_EX_Rw == IF_ID_Ra | (IF_ID_UseRb & ID_EX_Rw == IF_ID_Rb)).
  - If it holds with no freeze and no flush: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for that cycle only. The bubble clears ID_EX_MemRead, so the stall is exactly one cycle.
- Register 31 (XZR) never creates a hazard.
- Priority: freeze > branch flush > load-use.

## Timing
- Control outputs are combinational (Mealy) from state and inputs, with zero latency. State and counters update on the rising edge.
- While reset=0:
  - state=RUN, counters 0.
  - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Write=0.
  - MEM_WB_Bubble=1, IF_ID_Flush=1, ID_EX_Flush=1, ID_EX_Bubble=0.
  - dmem_req=0, mem_fault=0.
- Reset asserted mid-MEM_WAIT or mid-FLUSH aborts immediately. A pending request is dropped.
- Zero-wait access (ack in the request cycle) gives no freeze and does not enter MEM_WAIT.
- Maximum freeze length is MEM_TIMEOUT cycles. The timeout cycle follows the last freeze cycle.
- dmem_ack while dmem_req=0 is ignored.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles counts cycles with PC_Write=0 while reset=1.
  - flush_count counts taken-branch flush events, not flush cycles.
  - Both saturate at all-ones and clear on reset.
- HAZARD_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_Rw=5, IF_ID_Ra=5 → exactly one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. Repeating with Rw=31 → no stall.
- Memory wait: EX_MEM_MemAccess=1, dmem_ack high on the 4th cycle → 3 freeze cycles (write enables 0, MEM_WB_Bubble=1). Pipeline advances on cycle 4 and state returns to RUN.
- Timeout: MEM_TIMEOUT=4, ack never arrives → 4 freeze cycles, then one cycle with mem_fault=1, dmem_req=0, write enables 1.
- Branch plus load-use: FLUSH_CYCLES=2, EX_Branch_Taken coincides with a load-use match → flushes for 2 cycles, ID_EX_Bubble stays 0. Branch during freeze → flush starts in the ack cycle.
- Reset mid-MEM_WAIT: drive reset=0 at wait_cnt=2 → immediate reset output values. After release, state is RUN and dmem_req follows EX_MEM_MemAccess.
- With HAZARD_PERF_CNT_EN: 1 load-use stall + 3-cycle freeze + 1 branch → stall_cycles=4, flush_count=1. Without the macro, both read 0.

Source files
------------

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall, branch flush, dmem freeze.
// Optional perf counters built when HAZARD_PERF_CNT_EN is defined.
module hazard_control #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rw,
  input  logic [4:0]  IF_ID_Ra,
  input  logic [4:0]  IF_ID_Rb,
  input  logic        IF_ID_UseRb,
  input  logic        EX_Branch_Taken,
  input  logic        EX_MEM_MemAccess,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        MEM_WB_Bubble,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        mem_fault,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [7:0] TMO   = 8'(MEM_TIMEOUT);
  localparam logic [2:0] FLD   = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI = (FLUSH_CYCLES > 1);

  state_t     state, state_n;
  logic [7:0] wait_cnt, wait_n;
  logic [2:0] flush_cnt, flush_n;

  logic timeout, req, freeze, branch;
  logic flushing, hazard, stall;

  assign timeout = (state == MEM_WAIT) && (wait_cnt == TMO);
  assign req     = reset &
                   ((state == MEM_WAIT) ? ~timeout : EX_MEM_MemAccess);
  assign freeze  = req & ~dmem_ack;
  assign branch  = reset & EX_Branch_Taken & ~freeze;

  assign flushing = reset & ~freeze &
                    (branch | (state == FLUSH));

  assign hazard = ID_EX_MemRead && (ID_EX_Rw != 5'd31) &&
                  ((ID_EX_Rw == IF_ID_Ra) ||
                   (IF_ID_UseRb && (ID_EX_Rw == IF_ID_Rb)));

  assign stall = reset & hazard & ~freeze & ~flushing;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      flush_cnt <= flush_n;
    end
  end

  // a flush interrupted by a freeze resumes once memory releases
  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    flush_n = flush_cnt;
    unique case (state)
      RUN: begin
        if (freeze) begin
          state_n = MEM_WAIT;
          wait_n  = 8'd1;
        end else if (branch && MULTI) begin
          state_n = FLUSH;
          flush_n = FLD;
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          wait_n = wait_cnt + 8'd1;
        end else begin
          wait_n = '0;
          if (branch && MULTI) begin
            state_n = FLUSH;
            flush_n = FLD;
          end else if (flush_cnt != '0) begin
            state_n = FLUSH;
          end else begin
            state_n = RUN;
          end
        end
      end
      FLUSH: begin
        if (freeze) begin
          state_n = MEM_WAIT;
          wait_n  = 8'd1;
        end else if (branch) begin
          flush_n = FLD;
        end else if (flush_cnt <= 3'd1) begin
          state_n = RUN;
          flush_n = '0;
        end else begin
          flush_n = flush_cnt - 3'd1;
        end
      end
      default: begin
        state_n = RUN;
        wait_n  = '0;
        flush_n = '0;
      end
    endcase
  end

  always_comb begin
    dmem_req      = req;
    PC_Write      = reset & ~freeze & ~stall;
    IF_ID_Write   = reset & ~freeze & ~stall;
    ID_EX_Write   = reset & ~freeze;
    EX_MEM_Write  = reset & ~freeze;
    MEM_WB_Bubble = ~reset | freeze;
    ID_EX_Bubble  = stall;
    IF_ID_Flush   = ~reset | flushing;
    ID_EX_Flush   = ~reset | flushing;
    mem_fault     = reset & timeout;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PC_Write && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (branch && (flush_q != '1))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_hazard_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic [4:0]  rw, ra, rb;
  logic        use_rb, br, mem_acc, ack;
  logic        dmem_req, pc_w, ifid_w, idex_w, exmem_w;
  logic        wb_bub, idex_bub, ifid_fl, idex_fl, fault;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_control #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(rst_n),
    .ID_EX_MemRead(mem_read), .ID_EX_Rw(rw),
    .IF_ID_Ra(ra), .IF_ID_Rb(rb), .IF_ID_UseRb(use_rb),
    .EX_Branch_Taken(br), .EX_MEM_MemAccess(mem_acc),
    .dmem_ack(ack), .dmem_req(dmem_req),
    .PC_Write(pc_w), .IF_ID_Write(ifid_w),
    .ID_EX_Write(idex_w), .EX_MEM_Write(exmem_w),
    .MEM_WB_Bubble(wb_bub), .ID_EX_Bubble(idex_bub),
    .IF_ID_Flush(ifid_fl), .ID_EX_Flush(idex_fl),
    .mem_fault(fault), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  // pcw ifw idw exw wbb bub iff idf req fault
  logic [9:0] outs;
  assign outs = {pc_w, ifid_w, idex_w, exmem_w, wb_bub,
                 idex_bub, ifid_fl, idex_fl, dmem_req, fault};

  localparam logic [9:0] O_IDLE  = 10'b1111_0_0_00_0_0;
  localparam logic [9:0] O_STALL = 10'b0011_0_1_00_0_0;
  localparam logic [9:0] O_FLUSH = 10'b1111_0_0_11_0_0;
  localparam logic [9:0] O_REQOK = 10'b1111_0_0_00_1_0;
  localparam logic [9:0] O_FRZ   = 10'b0000_1_0_00_1_0;
  localparam logic [9:0] O_RST   = 10'b0000_1_0_11_0_0;
  localparam logic [9:0] O_TMO   = 10'b1111_0_0_00_0_1;

  typedef struct {
    string      nm;
    logic       rst;
    logic       mr;
    logic [4:0] w, a, b;
    logic       ub, bt, ma, ak;
    logic [9:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [4:0] w,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic u, input logic t,
                       input logic c, input logic k);
    mem_read = m; rw = w; ra = a; rb = b;
    use_rb = u; br = t; mem_acc = c; ack = k;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cyc(input string nm, input logic [9:0] exp);
    #1;
    chk(nm, 32'(outs), 32'(exp));
    @(negedge clk);
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{"reset_vals", 0, 1, 5, 5, 0, 0, 1, 1, 0, O_RST};
    vt[1]  = '{"idle",       1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE};
    vt[2]  = '{"lu_ra",      1, 1, 5, 5, 0, 0, 0, 0, 0, O_STALL};
    vt[3]  = '{"lu_xzr",     1, 1,31,31,31, 1, 0, 0, 0, O_IDLE};
    vt[4]  = '{"lu_rb",      1, 1, 7, 1, 7, 1, 0, 0, 0, O_STALL};
    vt[5]  = '{"lu_rb_nouse",1, 1, 7, 1, 7, 0, 0, 0, 0, O_IDLE};
    vt[6]  = '{"no_load",    1, 0, 5, 5, 5, 1, 0, 0, 0, O_IDLE};
    vt[7]  = '{"branch",     1, 0, 0, 0, 0, 0, 1, 0, 0, O_FLUSH};
    vt[8]  = '{"br_over_lu", 1, 1, 5, 5, 0, 0, 1, 0, 0, O_FLUSH};
    vt[9]  = '{"zero_wait",  1, 0, 0, 0, 0, 0, 0, 1, 1, O_REQOK};
    vt[10] = '{"freeze",     1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ};
    vt[11] = '{"frz_over_all",1,1, 5, 5, 0, 0, 1, 1, 0, O_FRZ};
    vt[12] = '{"ack_no_req", 1, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE};

    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);

    foreach (vt[i]) begin
      do_reset();
      rst_n = vt[i].rst;
      drive(vt[i].mr, vt[i].w, vt[i].a, vt[i].b,
            vt[i].ub, vt[i].bt, vt[i].ma, vt[i].ak);
      cyc(vt[i].nm, vt[i].exp);
    end
    rst_n = 1'b1;

    // load-use: bubble clears MemRead, so one stall cycle
    idle(); do_reset();
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    cyc("lu_seq_c1", O_STALL);
    drive(0, 5, 5, 0, 0, 0, 0, 0);
    cyc("lu_seq_c2", O_IDLE);

    // memory wait: ack on 4th cycle
    idle(); do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw_c1", O_FRZ);
    cyc("mw_c2", O_FRZ);
    cyc("mw_c3", O_FRZ);
    ack = 1;
    cyc("mw_ack", O_REQOK);
    idle();
    cyc("mw_run", O_IDLE);

    // timeout: ack never comes
    idle(); do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("tmo_frz%0d", i), O_FRZ);
    cyc("tmo_fault", O_TMO);
    cyc("tmo_rerun", O_FRZ);

    // branch with load-use, 2 flush cycles
    idle(); do_reset();
    drive(1, 5, 5, 0, 0, 1, 0, 0);
    cyc("brlu_c1", O_FLUSH);
    br = 0;
    cyc("brlu_c2", O_FLUSH);
    cyc("brlu_c3", O_STALL);

    // branch held by freeze acts on ack cycle
    idle(); do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    cyc("brfz_c1", O_FRZ);
    cyc("brfz_c2", O_FRZ);
    ack = 1;
    cyc("brfz_ack", O_FLUSH | O_REQOK);
    idle();
    cyc("brfz_c4", O_FLUSH);
    cyc("brfz_c5", O_IDLE);

    // reset in MEM_WAIT at wait_cnt=2
    idle(); do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("rmw_c1", O_FRZ);
    cyc("rmw_c2", O_FRZ);
    rst_n = 1'b0;
    cyc("rmw_rst", O_RST);
    rst_n = 1'b1;
    mem_acc = 0;
    cyc("rmw_noreq", O_IDLE);
    mem_acc = 1; ack = 1;
    cyc("rmw_req", O_REQOK);

    // perf: 1 load-use + 3 freeze + 1 branch
    idle(); do_reset();
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    cyc("pf_lu", O_STALL);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("pf_f1", O_FRZ);
    cyc("pf_f2", O_FRZ);
    cyc("pf_f3", O_FRZ);
    ack = 1;
    cyc("pf_ack", O_REQOK);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    cyc("pf_br", O_FLUSH);
    idle();
    cyc("pf_fl2", O_FLUSH);
    cyc("pf_idle", O_IDLE);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, 32'd4);
    chk("flush_count", 32'(flush_count), 32'd1);
`else
    chk("stall_cycles", stall_cycles, 32'd0);
    chk("flush_count", 32'(flush_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
